// File: rtl/uart_rx_axis_fifo.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_axis_fifo
// Description : 8N1 UART receiver. Received bytes go into a first-word-fall-
//               through FIFO and leave through an AXI-Stream master port.
//               A byte equal to LAST_CHAR is tagged with m_axis_last.
//               Frame errors and overruns are reported as one-cycle pulses.
// Ports       : clk, rst (async, active-high)
//               uart_rx                       serial input, idle high
//               m_axis_data/valid/last/ready  AXI-Stream master
//               frame_err                     pulse: stop bit sampled low
//               overrun                       pulse: good byte dropped, FIFO full
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_axis_fifo #(
    parameter int               WIDTH     = 8,
    parameter int               DEPTH     = 8,
    parameter int               CLK_RATE  = 100000000,
    parameter int               BAUD      = 115200,
    parameter logic [WIDTH-1:0] LAST_CHAR = 8'h0A
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             uart_rx,
    output logic [WIDTH-1:0] m_axis_data,
    output logic             m_axis_valid,
    output logic             m_axis_last,
    input  logic             m_axis_ready,
    output logic             frame_err,
    output logic             overrun
);

    localparam int c_cpb = CLK_RATE / BAUD;
    localparam int c_cw  = (c_cpb > 1) ? $clog2(c_cpb) : 1;
    localparam int c_bw  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int c_aw  = $clog2(DEPTH);

    localparam logic [c_cw-1:0] c_cnt_last = c_cw'(c_cpb - 1);
    localparam logic [c_cw-1:0] c_cnt_half = c_cw'(c_cpb / 2 - 1);
    localparam logic [c_bw-1:0] c_bit_last = c_bw'(WIDTH - 1);
    localparam logic [c_aw:0]   c_full_cnt = (c_aw + 1)'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    state_t           r_state, w_state_nxt;
    logic [1:0]       r_sync;
    logic             w_rx_s;
    logic [c_cw-1:0]  r_cnt;
    logic [c_bw-1:0]  r_bit;
    logic [WIDTH-1:0] r_shift;
    logic             r_ferr, r_ovr;

    logic             w_cnt_end, w_cnt_clr, w_bit_clr, w_shift;
    logic             w_push, w_ferr, w_ovr, w_pop, w_full;

    logic [WIDTH:0]   r_mem [DEPTH];
    logic [c_aw-1:0]  r_wr_ptr, r_rd_ptr;
    logic [c_aw:0]    r_count;
    logic [WIDTH:0]   w_head;

    assign w_rx_s    = r_sync[1];
    assign w_cnt_end = (r_cnt == c_cnt_last);
    assign w_full    = (r_count == c_full_cnt);
    assign w_pop     = m_axis_valid && m_axis_ready;

    // ------------------------------------------------------------------
    // Receive FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Receive FSM: next state and datapath controls
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_clr   = 1'b0;
        w_bit_clr   = 1'b0;
        w_shift     = 1'b0;
        w_push      = 1'b0;
        w_ferr      = 1'b0;
        w_ovr       = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_cnt_clr = 1'b1;
                if (!w_rx_s) begin
                    w_state_nxt = S_START;
                end
            end
            S_START: begin
                w_bit_clr = 1'b1;
                if (r_cnt == c_cnt_half) begin
                    w_cnt_clr   = 1'b1;
                    // A start bit that is high again at mid-bit was a glitch.
                    w_state_nxt = w_rx_s ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (w_cnt_end) begin
                    w_shift = 1'b1;
                    if (r_bit == c_bit_last) begin
                        w_state_nxt = S_STOP;
                    end
                end
            end
            S_STOP: begin
                // Leaving at mid-stop-bit lets a back-to-back start edge be caught.
                if (w_cnt_end) begin
                    w_state_nxt = S_IDLE;
                    if (!w_rx_s) begin
                        w_ferr = 1'b1;
                    end else if (w_full) begin
                        w_ovr = 1'b1;
                    end else begin
                        w_push = 1'b1;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Synchronizer, bit timing, shift register, status pulses
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync  <= 2'b11;   // preset high so reset release never looks like a start bit
            r_cnt   <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_ferr  <= 1'b0;
            r_ovr   <= 1'b0;
        end else begin
            r_sync <= {r_sync[0], uart_rx};
            r_cnt  <= (w_cnt_clr || w_cnt_end) ? '0 : r_cnt + c_cw'(1);
            if (w_bit_clr) begin
                r_bit <= '0;
            end else if (w_shift) begin
                r_bit <= r_bit + c_bw'(1);
            end
            if (w_shift) begin
                r_shift <= {w_rx_s, r_shift[WIDTH-1:1]};
            end
            r_ferr <= w_ferr;
            r_ovr  <= w_ovr;
        end
    end

    // ------------------------------------------------------------------
    // FIFO storage: {last, data}; not reset, outputs are gated by valid
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {(r_shift == LAST_CHAR), r_shift};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_aw'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_aw'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (c_aw + 1)'(1);
                2'b01:   r_count <= r_count - (c_aw + 1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign w_head       = r_mem[r_rd_ptr];
    assign m_axis_valid = (r_count != '0);
    assign m_axis_data  = m_axis_valid ? w_head[WIDTH-1:0] : '0;
    assign m_axis_last  = m_axis_valid ? w_head[WIDTH] : 1'b0;
    assign frame_err    = r_ferr;
    assign overrun      = r_ovr;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_axis_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx_axis_fifo
// Description : Self-checking bench for uart_rx_axis_fifo (CPB=10, DEPTH=4).
//               Frame vector table, hand-written corner sequences, and random
//               frames compared against a queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_axis_fifo;

    localparam int CPB = 10;

    logic       clk = 1'b0;
    logic       rst;
    logic       uart_rx;
    logic [7:0] m_axis_data;
    logic       m_axis_valid;
    logic       m_axis_last;
    logic       m_axis_ready;
    logic       frame_err;
    logic       overrun;

    int checks = 0;
    int errors = 0;

    logic [8:0] got_q[$];
    logic [8:0] exp_q[$];
    int         ferr_cnt = 0;
    int         ovr_cnt  = 0;
    int         exp_ferr = 0;
    logic       rand_run = 1'b0;

    always #5 clk = ~clk;

    uart_rx_axis_fifo #(
        .WIDTH    (8),
        .DEPTH    (4),
        .CLK_RATE (1000000),
        .BAUD     (100000),
        .LAST_CHAR(8'h0A)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .uart_rx     (uart_rx),
        .m_axis_data (m_axis_data),
        .m_axis_valid(m_axis_valid),
        .m_axis_last (m_axis_last),
        .m_axis_ready(m_axis_ready),
        .frame_err   (frame_err),
        .overrun     (overrun)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Wait n cycles, leaving the driver 1 time unit after a rising edge.
    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One 8N1 frame at exactly CPB clocks per bit; stop level selectable.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        uart_rx = 1'b0;
        idle(CPB);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            idle(CPB);
        end
        uart_rx = stop_bit;
        idle(CPB);
        uart_rx = 1'b1;
    endtask

    // Monitor: collects beats and pulses, and checks head stability under backpressure.
    logic       pv = 1'b0;
    logic       pr = 1'b0;
    logic       pl = 1'b0;
    logic [7:0] pd = 8'h00;

    always @(negedge clk) begin
        if (rst) begin
            pv <= 1'b0;
        end else begin
            if (pv && !pr) begin
                chk("hold_valid", {31'd0, m_axis_valid}, 32'd1);
                chk("hold_data", {24'd0, m_axis_data}, {24'd0, pd});
                chk("hold_last", {31'd0, m_axis_last}, {31'd0, pl});
            end
            if (m_axis_valid && m_axis_ready) got_q.push_back({m_axis_last, m_axis_data});
            if (frame_err) ferr_cnt++;
            if (overrun) ovr_cnt++;
            pv <= m_axis_valid;
            pr <= m_axis_ready;
            pd <= m_axis_data;
            pl <= m_axis_last;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    typedef struct {
        logic [7:0] data;
        logic       stop;
        int         exp_beats;
        logic [7:0] exp_data;
        logic       exp_last;
        int         exp_ferr;
    } vec_t;

    vec_t vecs[6];
    logic seen_valid;

    initial begin
        vecs[0] = '{8'hA5, 1'b1, 1, 8'hA5, 1'b0, 0};
        vecs[1] = '{8'h0A, 1'b1, 1, 8'h0A, 1'b1, 0};
        vecs[2] = '{8'h00, 1'b1, 1, 8'h00, 1'b0, 0};
        vecs[3] = '{8'hFF, 1'b1, 1, 8'hFF, 1'b0, 0};
        vecs[4] = '{8'h55, 1'b0, 0, 8'h00, 1'b0, 1};
        vecs[5] = '{8'h0B, 1'b1, 1, 8'h0B, 1'b0, 0};

        // ---- Reset ----
        rst = 1'b1;
        uart_rx = 1'b1;
        m_axis_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_valid", {31'd0, m_axis_valid}, 32'd0);
        chk("rst_data", {24'd0, m_axis_data}, 32'd0);
        chk("rst_last", {31'd0, m_axis_last}, 32'd0);
        chk("rst_ferr", {31'd0, frame_err}, 32'd0);
        chk("rst_ovr", {31'd0, overrun}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        seen_valid = 1'b0;
        repeat (200) begin
            @(negedge clk);
            if (m_axis_valid) seen_valid = 1'b1;
        end
        chk("post_rst_no_valid", {31'd0, seen_valid}, 32'd0);

        // ---- Single byte with valid timing ----
        m_axis_ready = 1'b1;
        idle(1);
        fork
            send_frame(8'hA5, 1'b1);
            begin
                repeat (98) @(negedge clk);
                chk("t2_valid_before", {31'd0, m_axis_valid}, 32'd0);
                @(negedge clk);
                chk("t2_valid_rise", {31'd0, m_axis_valid}, 32'd1);
                chk("t2_data", {24'd0, m_axis_data}, 32'hA5);
                chk("t2_last", {31'd0, m_axis_last}, 32'd0);
                @(negedge clk);
                chk("t2_valid_one_cycle", {31'd0, m_axis_valid}, 32'd0);
            end
        join
        idle(10);

        // ---- Delimiter and back-to-back ----
        got_q.delete();
        send_frame(8'h31, 1'b1);
        send_frame(8'h32, 1'b1);
        send_frame(8'h0A, 1'b1);
        idle(20);
        chk("t3_beats", got_q.size(), 32'd3);
        if (got_q.size() == 3) begin
            chk("t3_beat0", {23'd0, got_q[0]}, 32'h031);
            chk("t3_beat1", {23'd0, got_q[1]}, 32'h032);
            chk("t3_beat2", {23'd0, got_q[2]}, 32'h10A);
        end

        // ---- Vector table: single frames ----
        for (int i = 0; i < 6; i++) begin
            got_q.delete();
            ferr_cnt = 0;
            send_frame(vecs[i].data, vecs[i].stop);
            idle(25);
            chk($sformatf("vec%0d_beats", i), got_q.size(), vecs[i].exp_beats);
            if (vecs[i].exp_beats == 1 && got_q.size() == 1) begin
                chk($sformatf("vec%0d_data", i), {24'd0, got_q[0][7:0]}, {24'd0, vecs[i].exp_data});
                chk($sformatf("vec%0d_last", i), {31'd0, got_q[0][8]}, {31'd0, vecs[i].exp_last});
            end
            chk($sformatf("vec%0d_ferr", i), ferr_cnt, vecs[i].exp_ferr);
        end

        // ---- Backpressure and overrun ----
        got_q.delete();
        ovr_cnt = 0;
        m_axis_ready = 1'b0;
        for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1);
        idle(5);
        chk("t4_overrun_pulses", ovr_cnt, 32'd1);
        chk("t4_head_valid", {31'd0, m_axis_valid}, 32'd1);
        chk("t4_head_data", {24'd0, m_axis_data}, 32'h01);
        m_axis_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            chk($sformatf("t4_drain%0d_valid", i), {31'd0, m_axis_valid}, 32'd1);
            chk($sformatf("t4_drain%0d_data", i), {24'd0, m_axis_data}, i);
        end
        @(negedge clk);
        chk("t4_drained_valid", {31'd0, m_axis_valid}, 32'd0);
        idle(5);

        // ---- Glitch, then a good frame ----
        got_q.delete();
        ferr_cnt = 0;
        uart_rx = 1'b0;
        idle(3);
        uart_rx = 1'b1;
        idle(30);
        chk("t5_glitch_beats", got_q.size(), 32'd0);
        chk("t5_glitch_ferr", ferr_cnt, 32'd0);
        send_frame(8'h66, 1'b1);
        idle(20);
        chk("t5_after_beats", got_q.size(), 32'd1);
        if (got_q.size() == 1) chk("t5_after_data", {23'd0, got_q[0]}, 32'h066);

        // ---- Reset mid-frame ----
        got_q.delete();
        m_axis_ready = 1'b0;
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        idle(5);
        chk("t6_queued_valid", {31'd0, m_axis_valid}, 32'd1);
        fork
            send_frame(8'hF8, 1'b1);
            begin
                idle(45);
                rst = 1'b1;
                @(negedge clk);
                chk("t6_rst_valid", {31'd0, m_axis_valid}, 32'd0);
                idle(2);
                rst = 1'b0;
            end
        join
        idle(20);
        chk("t6_flushed_valid", {31'd0, m_axis_valid}, 32'd0);
        m_axis_ready = 1'b1;
        send_frame(8'h7E, 1'b1);
        idle(20);
        chk("t6_next_beats", got_q.size(), 32'd1);
        if (got_q.size() == 1) chk("t6_next_data", {23'd0, got_q[0]}, 32'h07E);

        // ---- Random frames against the reference model ----
        got_q.delete();
        exp_q.delete();
        ferr_cnt = 0;
        ovr_cnt = 0;
        exp_ferr = 0;
        rand_run = 1'b1;
        fork
            begin
                while (rand_run) begin
                    @(posedge clk);
                    #1;
                    m_axis_ready = 1'($urandom_range(0, 1));
                end
            end
            begin
                for (int n = 0; n < 30; n++) begin
                    logic [7:0] b;
                    logic       sb;
                    int         gap;
                    b   = ($urandom_range(0, 3) == 0) ? 8'h0A : 8'($urandom);
                    sb  = ($urandom_range(0, 7) != 0);
                    gap = $urandom_range(0, 4);
                    if (sb) begin
                        exp_q.push_back({(b == 8'h0A), b});
                    end else begin
                        exp_ferr++;
                        gap += 20;
                    end
                    send_frame(b, sb);
                    idle(gap);
                end
                idle(40);
                rand_run = 1'b0;
            end
        join
        m_axis_ready = 1'b1;
        idle(10);
        chk("rand_beats", got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            chk($sformatf("rand_beat%0d", i), {23'd0, got_q[i]}, {23'd0, exp_q[i]});
        end
        chk("rand_ferr", ferr_cnt, exp_ferr);
        chk("rand_ovr", ovr_cnt, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
